// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential multiply/divide ALU.
//   - Opcode encodings (OP_ADD .. OP_RSVD)
//   - FSM state encoding (ST_IDLE, ST_MUL, ST_DIV, ST_DONE)
//   - clog2 helper for sizing the iteration counter
package alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_SLT   = 3'b100;
    localparam logic [2:0] OP_MULTU = 3'b101;
    localparam logic [2:0] OP_DIVU  = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Number of bits needed to hold values 0 .. v-1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_core.sv
// alu_seq_core: combinational add/sub/logic/SLT slice.
// Ports:
//   op       opcode (only ADD/SUB/AND/OR/SLT produce non-zero results)
//   a, b     operands
//   res      slice result
//   cout     adder carry-out, ADD/SUB only (SUB: 1 = no borrow)
//   overflow signed overflow, ADD/SUB only
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int unsigned BUS = 8,
    parameter int unsigned OPW = 3
) (
    input  logic [OPW-1:0] op,
    input  logic [BUS-1:0] a,
    input  logic [BUS-1:0] b,
    output logic [BUS-1:0] res,
    output logic           cout,
    output logic           overflow
);

    logic           sub;
    logic [BUS-1:0] b_eff;
    logic [BUS-1:0] sum;
    logic           carry;
    logic           ovf_raw;

    // SLT reuses the subtractor: a < b (signed) is sign(a-b) xor overflow.
    assign sub   = (op == OP_SUB) || (op == OP_SLT);
    assign b_eff = sub ? ~b : b;
    assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{BUS{1'b0}}, sub};
    assign ovf_raw = (a[BUS-1] == b_eff[BUS-1]) && (sum[BUS-1] != a[BUS-1]);

    always_comb begin
        res      = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                res      = sum;
                cout     = carry;
                overflow = ovf_raw;
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_SLT:  res = {{(BUS-1){1'b0}}, sum[BUS-1] ^ ovf_raw};
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: multi-cycle EX-stage ALU with start/ready/valid handshake.
// Single-cycle ADD/SUB/AND/OR/SLT, shift-add MULTU and restoring DIVU (BUS cycles each).
// Build option: define ALU_DIV_EN to include the divider; otherwise DIVU acts as the
// reserved opcode and div_by_zero is always 0.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, op, a, b         request; sampled when start & ready
//   ready                   idle, can accept
//   valid                   one-cycle pulse when results/flags update
//   result_lo, result_hi    result/product low/quotient, product high/remainder
//   zero, cout, overflow, negative, div_by_zero   registered flags
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned BUS = 8,
    parameter int unsigned OPW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [OPW-1:0] op,
    input  logic [BUS-1:0] a,
    input  logic [BUS-1:0] b,
    output logic           ready,
    output logic           valid,
    output logic [BUS-1:0] result_lo,
    output logic [BUS-1:0] result_hi,
    output logic           zero,
    output logic           cout,
    output logic           overflow,
    output logic           negative,
    output logic           div_by_zero
);

    localparam int unsigned CW = clog2(BUS + 1);

    state_e state_q, state_d;

    logic [BUS-1:0]   a_q;
    logic [2*BUS-1:0] p_q, p_d;      // mul: {acc, multiplier}; div: {remainder, dividend/quotient}
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic             accept, last, is_mul, is_divu, is_div, is_dbz;

    logic [BUS-1:0]   core_res;
    logic             core_cout, core_ovf;
    logic [BUS:0]     mul_sum;
    logic [2*BUS-1:0] mul_p;

    logic             load;
    logic [BUS-1:0]   fin_lo, fin_hi;
    logic             fin_cout, fin_ovf, fin_dbz;

    logic [BUS-1:0]   lo_q, hi_q;
    logic             zero_q, cout_q, ovf_q, neg_q, dbz_q;

    alu_seq_core #(
        .BUS (BUS),
        .OPW (OPW)
    ) u_core (
        .op       (op),
        .a        (a),
        .b        (b),
        .res      (core_res),
        .cout     (core_cout),
        .overflow (core_ovf)
    );

    assign accept  = start && (state_q == ST_IDLE);
    assign is_mul  = (op == OP_MULTU);
`ifdef ALU_DIV_EN
    assign is_divu = (op == OP_DIVU);
`else
    assign is_divu = 1'b0;
`endif
    assign is_div  = is_divu && (b != '0);
    assign is_dbz  = is_divu && (b == '0);
    assign last    = (cnt_q == CW'(BUS - 1));
    assign cnt_inc = (cnt_q == CW'(BUS)) ? cnt_q : cnt_q + 1'b1;

    // One shift-add step: add multiplicand if multiplier LSB set, then shift right.
    assign mul_sum = {1'b0, p_q[2*BUS-1:BUS]} + {1'b0, (p_q[0] ? a_q : {BUS{1'b0}})};
    assign mul_p   = {mul_sum, p_q[BUS-1:1]};

`ifdef ALU_DIV_EN
    logic [BUS-1:0]   b_q;
    logic [BUS:0]     div_sh, div_diff;
    logic [2*BUS-1:0] div_p;

    // Restoring step: shift in next dividend bit, subtract if it fits.
    assign div_sh   = {p_q[2*BUS-1:BUS], p_q[BUS-1]};
    assign div_diff = div_sh - {1'b0, b_q};
    assign div_p    = div_diff[BUS] ? {div_sh[BUS-1:0], p_q[BUS-2:0], 1'b0}
                                    : {div_diff[BUS-1:0], p_q[BUS-2:0], 1'b1};
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul)      state_d = ST_MUL;
                    else if (is_div) state_d = ST_DIV;
                    else             state_d = ST_DONE;
                end
            end
            ST_MUL:  if (last) state_d = ST_DONE;
`ifdef ALU_DIV_EN
            ST_DIV:  if (last) state_d = ST_DONE;
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        ready = (state_q == ST_IDLE);
        valid = (state_q == ST_DONE);
    end

    // Datapath next-state and result capture
    always_comb begin
        p_d      = p_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        fin_lo   = '0;
        fin_hi   = '0;
        fin_cout = 1'b0;
        fin_ovf  = 1'b0;
        fin_dbz  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (is_mul) begin
                        p_d = {{BUS{1'b0}}, b};
                    end else if (is_div) begin
                        p_d = {{BUS{1'b0}}, a};
                    end else if (is_dbz) begin
                        load    = 1'b1;
                        fin_lo  = '1;
                        fin_hi  = a;
                        fin_dbz = 1'b1;
                    end else begin
                        load     = 1'b1;
                        fin_lo   = core_res;
                        fin_cout = core_cout;
                        fin_ovf  = core_ovf;
                    end
                end
            end
            ST_MUL: begin
                p_d   = mul_p;
                cnt_d = cnt_inc;
                if (last) begin
                    load   = 1'b1;
                    fin_lo = mul_p[BUS-1:0];
                    fin_hi = mul_p[2*BUS-1:BUS];
                end
            end
`ifdef ALU_DIV_EN
            ST_DIV: begin
                p_d   = div_p;
                cnt_d = cnt_inc;
                if (last) begin
                    load   = 1'b1;
                    fin_lo = div_p[BUS-1:0];
                    fin_hi = div_p[2*BUS-1:BUS];
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            p_q   <= '0;
            cnt_q <= '0;
        end else begin
            if (accept) a_q <= a;
            p_q   <= p_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef ALU_DIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q <= '0;
        end else if (accept) begin
            b_q <= b;
        end
    end
`endif

    // Results only change on the edge that enters DONE, so they hold while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q   <= '0;
            hi_q   <= '0;
            zero_q <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            neg_q  <= 1'b0;
            dbz_q  <= 1'b0;
        end else if (load) begin
            lo_q   <= fin_lo;
            hi_q   <= fin_hi;
            zero_q <= (fin_lo == '0);
            cout_q <= fin_cout;
            ovf_q  <= fin_ovf;
            neg_q  <= fin_lo[BUS-1];
            dbz_q  <= fin_dbz;
        end
    end

    assign result_lo   = lo_q;
    assign result_hi   = hi_q;
    assign zero        = zero_q;
    assign cout        = cout_q;
    assign overflow    = ovf_q;
    assign negative    = neg_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Self-checking bench for alu_seq_muldiv (BUS=8): directed cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_seq_muldiv;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'd0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic       ready, valid;
    logic [7:0] result_lo, result_hi;
    logic       zero, cout, overflow, negative, div_by_zero;

    int checks = 0;
    int errors = 0;
    logic [7:0] prev_lo = 8'd0;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [4:0] flags;   // {zero, cout, overflow, negative, div_by_zero}
        int         lat;
    } exp_t;

    alu_seq_muldiv #(
        .BUS (8),
        .OPW (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .ready       (ready),
        .valid       (valid),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .zero        (zero),
        .cout        (cout),
        .overflow    (overflow),
        .negative    (negative),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int sx, sy, ss, us;
        logic c, v, dz;
        sx = $signed(x);
        sy = $signed(y);
        e.lo = 8'd0; e.hi = 8'd0; e.lat = 1;
        c = 1'b0; v = 1'b0; dz = 1'b0;
        case (o)
            3'd0: begin
                us = int'(x) + int'(y);
                ss = sx + sy;
                e.lo = us[7:0];
                c = (us > 255);
                v = (ss > 127) || (ss < -128);
            end
            3'd1: begin
                ss = sx - sy;
                us = int'(x) - int'(y);
                e.lo = us[7:0];
                c = (x >= y);
                v = (ss > 127) || (ss < -128);
            end
            3'd2: e.lo = x & y;
            3'd3: e.lo = x | y;
            3'd4: e.lo = (sx < sy) ? 8'd1 : 8'd0;
            3'd5: begin
                us = int'(x) * int'(y);
                e.lo = us[7:0];
                e.hi = us[15:8];
                e.lat = 9;
            end
            3'd6: begin
`ifdef ALU_DIV_EN
                if (y == 8'd0) begin
                    e.lo = 8'hFF;
                    e.hi = x;
                    dz = 1'b1;
                end else begin
                    e.lo = x / y;
                    e.hi = x % y;
                    e.lat = 9;
                end
`endif
            end
            default: ;
        endcase
        e.flags = {(e.lo == 8'd0), c, v, e.lo[7], dz};
        return e;
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                          input bit noise);
        exp_t e;
        int lat;
        e = model(o, x, y);
        @(negedge clk);
        check("ready_idle", ready, 1);
        check("valid_idle", valid, 0);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!valid && lat < 40) begin
            check("busy_ready", ready, 0);
            check("busy_hold", result_lo, prev_lo);
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                op = 3'($urandom);
                a = 8'($urandom);
                b = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check($sformatf("latency op%0d", o), lat, e.lat);
        check($sformatf("lo op%0d %0h,%0h", o, x, y), result_lo, e.lo);
        check($sformatf("hi op%0d %0h,%0h", o, x, y), result_hi, e.hi);
        check($sformatf("flags op%0d %0h,%0h", o, x, y),
              {zero, cout, overflow, negative, div_by_zero}, e.flags);
        check("done_ready", ready, 0);
        prev_lo = e.lo;
    endtask

    initial begin
        #12;
        check("rst_ready", ready, 1);
        check("rst_valid", valid, 0);
        check("rst_res", {result_hi, result_lo}, 16'd0);
        check("rst_flags", {zero, cout, overflow, negative, div_by_zero}, 5'd0);
        rst_n = 1'b1;

        run_op(3'd0, 8'h7F, 8'h01, 1'b0);     // ADD overflow
        run_op(3'd1, 8'd5, 8'd5, 1'b0);       // SUB -> zero
        run_op(3'd4, 8'hFE, 8'h01, 1'b0);     // SLT -2 < 1
        run_op(3'd5, 8'hFF, 8'hFF, 1'b1);     // MULTU with ignored starts
        run_op(3'd6, 8'd200, 8'd7, 1'b1);     // DIVU
        run_op(3'd6, 8'd9, 8'd0, 1'b0);       // DIVU by zero
        run_op(3'd7, 8'h12, 8'h34, 1'b0);     // reserved

        // Reset in the middle of a multiply.
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 8'hAB; b = 8'hCD;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", ready, 1);
        check("midrst_valid", valid, 0);
        check("midrst_res", {result_hi, result_lo}, 16'd0);
        check("midrst_flags", {zero, cout, overflow, negative, div_by_zero}, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_lo = 8'd0;
        run_op(3'd0, 8'd3, 8'd4, 1'b0);

        // Back-to-back: ADD accepted in the ready cycle right after MULTU's valid.
        run_op(3'd5, 8'd13, 8'd21, 1'b0);
        run_op(3'd0, 8'h80, 8'h80, 1'b0);

        for (int i = 0; i < 150; i++) begin
            logic [7:0] rb;
            rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            run_op(3'($urandom_range(0, 7)), 8'($urandom), rb, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
